serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder built around the existing one-bit `fa` cell. It accepts two parallel operands and a carry-in on a start strobe, then feeds them LSB-first through a single `fa` instance, one bit per clock. The carry-out is held in a flip-flop between bits, and the sum bits are collected in a shift register. It sits directly above `fa`, both feeding it and consuming its `s`/`cout`, and gives the datapath an area-cheap multi-bit adder.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range ≥ 1.

- `clk`  in  1  the only clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `a_in`  in  WIDTH  operand A; captured when start is accepted.
- `b_in`  in  WIDTH  operand B; captured when start is accepted.
- `cin_in`  in  1  carry-in; captured when start is accepted.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; result valid.
- `sum`  out  WIDTH  registered result of the last completed add.
- `cout`  out  1  registered carry-out of the last completed add.

## Operation
- Internal `fa` instance, positional connection (a, b, cin, s, cout):
  - a = A shift reg bit 0
  - b = B shift reg bit 0
  - cin = carry flop
- FSM states:
  - IDLE → SHIFT on start=1:
    - load A ← a_in, B ← b_in, carry ← cin_in
    - bit count ← 0
  - SHIFT, every cycle:
    - A, B shift right by 1, zero fill
    - sum shift reg ← {fa.s, sumsr[WIDTH-1:1]}
    - carry ← fa.cout
    - count ← count+1
    - when count == WIDTH-1: go to DONE; also load `sum` ← {fa.s, sumsr[WIDTH-1:1]} and `cout` ← fa.cout
  - DONE → IDLE unconditionally after one cycle.
- `done` = (state == DONE), decoded from a registered state only; no combinational path from inputs.
- Result semantics: {cout, sum} = a_in + b_in + cin_in, modulo 2^(WIDTH+1), i.e. exact.
- `sum`/`cout` change only on the completing edge. They hold their value through IDLE and through the SHIFT phase of the next operation.
- start while busy (SHIFT or DONE): ignored, not queued; operands are not re-sampled.
- a_in/b_in/cin_in may change freely after the accept edge without affecting the result.
- WIDTH=1: exactly one SHIFT cycle; the count compare is true on the first SHIFT cycle.
- Count register width: clog2(WIDTH) bits, minimum 1; it never exceeds WIDTH-1.

## Timing
- Reset, asynchronous on rst_n low:
  - state = IDLE, busy=0, done=0
  - sum=0, cout=0
  - A, B, sum shift regs, carry and count = 0
- Reset asserted mid-operation: the operation is abandoned immediately. The previous result is lost; outputs read 0.
- Reset release: first start is accepted on the first rising edge where rst_n=1.
- Latency, with start accepted at edge 0:
  - busy=1 from edge 0
  - bits 0..WIDTH-1 processed at edges 1..WIDTH
  - sum/cout updated and done=1 from edge WIDTH to edge WIDTH+1
  - busy=0 after edge WIDTH+1
- Throughput: next start can be accepted at edge WIDTH+2 at the earliest, so one add per WIDTH+2 cycles.
- done is never high for more than one cycle. busy is 1 whenever done is 1.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0:
  - done at 8 cycles after the accept edge
  - sum=0x96, cout=0
  - busy high for exactly 9 cycles
- WIDTH=8, a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1. Issue the second start at the earliest legal edge to check back-to-back throughput.
- Pulse start again at the 3rd SHIFT cycle with a=0x00, b=0x00:
  - the in-flight result (0x12+0x34 → 0x46, cout 0) completes unchanged
  - no second done pulse occurs
- Start 0x80+0x80, cin=0, then assert rst_n=0 at the 4th SHIFT cycle:
  - busy, done, sum, cout all 0 immediately
  - after release, a new 0x01+0x02 gives 0x03 on schedule
- WIDTH=3, exhaustive: all 128 combinations of a, b, cin checked against {cout,sum} = a+b+cin, with done pulse timing checked each time.
- WIDTH=1: a=1, b=1, cin=1 → sum=1, cout=1. done appears 1 cycle after the accept edge.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: the requester drives the
// start strobe and operands, the adder returns status, result and FSM state.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [1:0]       dbg_state;

    // Handshake: start is taken only while busy=0; done pulses for one cycle
    // when sum/cout have just been updated; start while busy is dropped.
    modport master (
        output start, a_in, b_in, cin_in,
        input  busy, done, sum, cout, dbg_state
    );

    modport slave (
        input  start, a_in, b_in, cin_in,
        output busy, done, sum, cout, dbg_state
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands stream LSB-first through one full-adder
// cell, carry is held in a flop between bits, sum bits collect in a shift reg.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sumsr;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_s;
    logic             w_co;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_busy;
    logic             w_done;

    fa u_fa (r_a[0], r_b[0], r_carry, w_s, w_co);

    assign w_last = (r_state == SHIFT) && (r_cnt == LAST);

    // The newest sum bit enters at the MSB so bit 0 ends up at position 0.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_sum_next = w_s;
        end else begin : g_wn
            assign w_sum_next = {w_s, r_sumsr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != IDLE);
        w_done = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sumsr <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a_in;
                        r_b     <= bus.b_in;
                        r_carry <= bus.cin_in;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_sumsr <= w_sum_next;
                    r_carry <= w_co;
                    // Count returns to 0 on the last bit so it never passes WIDTH-1.
                    r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_last) begin
                        r_sum  <= w_sum_next;
                        r_cout <= w_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8, 3 and 1: table-driven adds,
// busy-time start pokes, mid-operation reset and an exhaustive 3-bit sweep.
module tb_serial_adder;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [8:0] prev8;
    logic [3:0] prev3;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] esum;
        logic       ecout;
        int         poke;
        int         extra;
        string      name;
    } vec_t;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(3)) if3 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    serial_adder #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic op8(input vec_t v);
        int busy_n;
        @(negedge clk);
        if8.start = 1'b1; if8.a_in = v.a; if8.b_in = v.b; if8.cin_in = v.cin;
        @(posedge clk); #1;
        if8.start = 1'b0;
        if8.a_in = 8'($urandom_range(0, 255));
        if8.b_in = 8'($urandom_range(0, 255));
        if8.cin_in = 1'($urandom_range(0, 1));
        chk({v.name, "_busy_accept"}, 32'(if8.busy), 32'd1);
        busy_n = 1;
        for (int k = 1; k <= 9 + v.extra; k++) begin
            @(posedge clk); #1;
            if8.start = 1'b0;
            busy_n += int'(if8.busy);
            chk($sformatf("%s_done_k%0d", v.name, k), 32'(if8.done), 32'(k == 8));
            if (k == 7) chk({v.name, "_hold"}, 32'({if8.cout, if8.sum}), 32'(prev8));
            if (k == 8) begin
                chk({v.name, "_sum"}, 32'(if8.sum), 32'(v.esum));
                chk({v.name, "_cout"}, 32'(if8.cout), 32'(v.ecout));
                prev8 = {v.ecout, v.esum};
            end
            if (k == v.poke) begin
                if8.start = 1'b1; if8.a_in = 8'h00; if8.b_in = 8'h00; if8.cin_in = 1'b0;
            end
        end
        chk({v.name, "_busy_cycles"}, 32'(busy_n), 32'd9);
    endtask

    task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic c);
        logic [3:0] exp;
        exp = 4'(a) + 4'(b) + 4'(c);
        @(negedge clk);
        if3.start = 1'b1; if3.a_in = a; if3.b_in = b; if3.cin_in = c;
        @(posedge clk); #1;
        if3.start = 1'b0;
        if3.a_in = 3'($urandom_range(0, 7));
        if3.b_in = 3'($urandom_range(0, 7));
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("w3_done_%0d_%0d_%0d_k%0d", a, b, c, k), 32'(if3.done), 32'(k == 3));
            chk($sformatf("w3_busy_k%0d", k), 32'(if3.busy), 32'(k <= 3));
            if (k == 2) chk("w3_hold", 32'({if3.cout, if3.sum}), 32'(prev3));
            if (k == 3) begin
                chk($sformatf("w3_res_%0d_%0d_%0d", a, b, c), 32'({if3.cout, if3.sum}), 32'(exp));
                prev3 = exp;
            end
        end
    endtask

    vec_t vecs[6];

    initial begin
        total = 0; bad = 0; prev8 = '0; prev3 = '0;
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0, 0, "v5a_3c"};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 0, "vff_01"};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 0, "vff_ff_c"};
        vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 2, 3, "poke_busy"};
        vecs[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 8, 2, "poke_done"};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 0, 0, "v7f_01"};

        rst_n = 1'b0;
        if8.start = 0; if8.a_in = 0; if8.b_in = 0; if8.cin_in = 0;
        if3.start = 0; if3.a_in = 0; if3.b_in = 0; if3.cin_in = 0;
        if1.start = 0; if1.a_in = 0; if1.b_in = 0; if1.cin_in = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(if8.busy), 32'd0);
        chk("rst_done", 32'(if8.done), 32'd0);
        chk("rst_res", 32'({if8.cout, if8.sum}), 32'd0);
        chk("rst_state", 32'(if8.dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) op8(vecs[i]);

        // Reset during the 4th SHIFT cycle of 0x80+0x80.
        @(negedge clk);
        if8.start = 1'b1; if8.a_in = 8'h80; if8.b_in = 8'h80; if8.cin_in = 1'b0;
        @(posedge clk); #1;
        if8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(if8.busy), 32'd0);
        chk("mid_rst_done", 32'(if8.done), 32'd0);
        chk("mid_rst_sum", 32'(if8.sum), 32'd0);
        chk("mid_rst_cout", 32'(if8.cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev8 = '0;
        op8('{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0, 0, "after_rst"});

        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < 2; c++)
                    op3(3'(a), 3'(b), 1'(c));

        // WIDTH=1: a single SHIFT cycle.
        @(negedge clk);
        if1.start = 1'b1; if1.a_in = 1'b1; if1.b_in = 1'b1; if1.cin_in = 1'b1;
        @(posedge clk); #1;
        if1.start = 1'b0; if1.a_in = 1'b0; if1.b_in = 1'b0; if1.cin_in = 1'b0;
        chk("w1_busy0", 32'(if1.busy), 32'd1);
        chk("w1_done0", 32'(if1.done), 32'd0);
        @(posedge clk); #1;
        chk("w1_done1", 32'(if1.done), 32'd1);
        chk("w1_res", 32'({if1.cout, if1.sum}), 32'd3);
        @(posedge clk); #1;
        chk("w1_done2", 32'(if1.done), 32'd0);
        chk("w1_busy2", 32'(if1.busy), 32'd0);
        chk("w1_hold", 32'({if1.cout, if1.sum}), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
